// File: rtl/bitclock_display_sequencer.sv
// Binary clock face sequencer: on each refresh request it snapshots the four
// BCD time digits and writes all 16 LEDs of the 4x4 face to the ws2812
// driver, one index per write strobe, with a programmable gap between writes.
//
// Handshake: there is no back-pressure from the driver. write is a one-cycle
// strobe that qualifies led_num and rgb_data in the same cycle. busy is high
// from the LOAD cycle through the DONE cycle, and done pulses for exactly one
// cycle when the last index and its gap have completed.
module bitclock_display_sequencer #(
  parameter logic [23:0] ON_COLOUR  = 24'h00_00_10,
  parameter logic [23:0] OFF_COLOUR = 24'h00_00_00,
  parameter int          WRITE_GAP  = 2,
  parameter bit          SERPENTINE = 1'b0
) (
  input  logic        hwclk,
  input  logic        reset,
  input  logic        update,
  input  logic [3:0]  dm0,
  input  logic [3:0]  dm1,
  input  logic [3:0]  dh0,
  input  logic [3:0]  dh1,
  output logic [7:0]  led_num,
  output logic [23:0] rgb_data,
  output logic        write,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Gap counter is loaded with WRITE_GAP-1 and expires when it reaches zero.
  localparam int          GAP_M1   = (WRITE_GAP > 0) ? WRITE_GAP - 1 : 0;
  localparam logic [7:0]  GAP_INIT = 8'(GAP_M1);

  state_t      state, state_next;
  logic [3:0]  idx, idx_next;
  logic [7:0]  gap_cnt, gap_next;
  logic [15:0] snap, snap_next;
  logic        pending, pending_next;
  logic        update_q;
  logic        rise;

  logic [7:0]  led_num_next;
  logic [23:0] rgb_data_next;
  logic        write_next;
  logic        busy_next;
  logic        done_next;

  // Colour for one LED: column picks the digit, row picks the bit; odd
  // columns are bit-reversed when the strip is wired zig-zag.
  function automatic logic [23:0] colour_for(input logic [15:0] word,
                                             input logic [3:0]  led);
    logic [1:0] col;
    logic [1:0] row;
    logic [3:0] digit;
    logic       bit_on;
    col   = led[3:2];
    row   = led[1:0];
    digit = word[{col, 2'b00} +: 4];
    if (SERPENTINE && col[0]) bit_on = digit[2'd3 - row];
    else                      bit_on = digit[row];
    return bit_on ? ON_COLOUR : OFF_COLOUR;
  endfunction

  assign rise = update & ~update_q;

  // Next-state, datapath and registered-output preparation.
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    gap_next     = gap_cnt;
    snap_next    = snap;
    pending_next = pending | rise;

    case (state)
      IDLE: begin
        if (pending || rise) state_next = LOAD;
      end
      LOAD: begin
        snap_next    = {dh1, dh0, dm1, dm0};
        pending_next = rise;
        idx_next     = 4'd0;
        state_next   = WRITE;
      end
      WRITE: begin
        if (WRITE_GAP == 0) begin
          if (idx == 4'd15) begin
            state_next = DONE;
          end else begin
            idx_next   = idx + 4'd1;
            state_next = WRITE;
          end
        end else begin
          gap_next   = GAP_INIT;
          state_next = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == 8'd0) begin
          if (idx == 4'd15) begin
            state_next = DONE;
          end else begin
            idx_next   = idx + 4'd1;
            state_next = WRITE;
          end
        end else begin
          gap_next = gap_cnt - 8'd1;
        end
      end
      DONE: begin
        state_next = (pending || rise) ? LOAD : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    write_next    = (state_next == WRITE);
    busy_next     = (state_next != IDLE);
    done_next     = (state_next == DONE);
    led_num_next  = led_num;
    rgb_data_next = rgb_data;
    if (state_next == WRITE) begin
      led_num_next  = {4'b0000, idx_next};
      rgb_data_next = colour_for(snap_next, idx_next);
    end
  end

  // State, datapath and output registers; reset arms a refresh via pending.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= 4'd0;
      gap_cnt  <= 8'd0;
      snap     <= 16'd0;
      pending  <= 1'b1;
      update_q <= 1'b0;
      led_num  <= 8'd0;
      rgb_data <= OFF_COLOUR;
      write    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      gap_cnt  <= gap_next;
      snap     <= snap_next;
      pending  <= pending_next;
      update_q <= update;
      led_num  <= led_num_next;
      rgb_data <= rgb_data_next;
      write    <= write_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

endmodule
